// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter feeding one UART transmitter stream.
// Each grant covers one burst, optionally led by a port ID header word.
module uart_tx_arbiter #(
  parameter int                   NUM_PORTS   = 4,
  parameter int                   WORD_SIZE   = 8,
  parameter int                   MAX_BURST   = 16,
  parameter bit                   HEADER_EN   = 1'b1,
  parameter logic [WORD_SIZE-1:0] HEADER_BASE = 8'hF0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  output logic [WORD_SIZE-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           active
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] SEL_LAST = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic [PW:0]   scan;

  // First valid port starting from ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan >= (PW+1)'(NUM_PORTS)) begin
        scan = scan - (PW+1)'(NUM_PORTS);
      end
      if (!pick_vld && s_axis_tvalid[scan[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[PW-1:0];
      end
    end
  end

  logic [WORD_SIZE-1:0] sel_data;
  logic [WORD_SIZE-1:0] hdr_word;

  assign sel_data = s_axis_tdata[sel_q*WORD_SIZE +: WORD_SIZE];
  assign hdr_word = HEADER_BASE | WORD_SIZE'(sel_q);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick_idx;
          cnt_d   = '0;
          state_d = HEADER_EN ? HEADER : DATA;
        end
      end
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_word;
        if (m_axis_tready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_axis_tdata         = sel_data;
        m_axis_tvalid        = s_axis_tvalid[sel_q];
        s_axis_tready[sel_q] = m_axis_tready;
        m_axis_tlast         = s_axis_tlast[sel_q]
                             | (cnt_q == CNT_LAST);
        if (m_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_q + CW'(1);
          if (m_axis_tlast) begin
            state_d = IDLE;
            ptr_d   = (sel_q == SEL_LAST) ? '0
                                          : sel_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state_q != IDLE) begin
      grant[sel_q] = 1'b1;
    end
  end

  assign active = (state_q != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; three instances share stimulus:
// default, MAX_BURST=4, and HEADER_EN=0 with MAX_BURST=1.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sd;
  logic [3:0]  sv, sl;
  logic        mr;

  logic [7:0] md0, md1, md2;
  logic       mv0, mv1, mv2;
  logic       ml0, ml1, ml2;
  logic [3:0] sr0, sr1, sr2;
  logic [3:0] g0, g1, g2;
  logic       act0, act1, act2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter u0 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(sd), .s_axis_tvalid(sv),
    .s_axis_tlast(sl), .s_axis_tready(sr0),
    .m_axis_tdata(md0), .m_axis_tvalid(mv0),
    .m_axis_tready(mr), .m_axis_tlast(ml0),
    .grant(g0), .active(act0)
  );

  uart_tx_arbiter #(.MAX_BURST(4)) u1 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(sd), .s_axis_tvalid(sv),
    .s_axis_tlast(sl), .s_axis_tready(sr1),
    .m_axis_tdata(md1), .m_axis_tvalid(mv1),
    .m_axis_tready(mr), .m_axis_tlast(ml1),
    .grant(g1), .active(act1)
  );

  uart_tx_arbiter #(.MAX_BURST(1), .HEADER_EN(1'b0)) u2 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(sd), .s_axis_tvalid(sv),
    .s_axis_tlast(sl), .s_axis_tready(sr2),
    .m_axis_tdata(md2), .m_axis_tvalid(mv2),
    .m_axis_tready(mr), .m_axis_tlast(ml2),
    .grant(g2), .active(act2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sv = '0;
    sl = '0;
    sd = '0;
    mr = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] got[$];
  logic [7:0] words[3];
  logic [7:0] w;
  logic [7:0] prev_d;
  logic       prev_stall;
  int         wi;

  initial begin
    rst_n = 1'b0;
    sv = '0;
    sl = '0;
    sd = '0;
    mr = 1'b1;
    #1;
    chk("rst_grant", 32'(g0), 32'h0);
    chk("rst_active", 32'(act0), 32'h0);
    chk("rst_mvalid", 32'(mv0), 32'h0);
    chk("rst_mlast", 32'(ml0), 32'h0);
    chk("rst_sready", 32'(sr0), 32'h0);
    chk("rst_mdata", 32'(md0), 32'h0);

    // Single request on port 2
    do_reset();
    sv = 4'b0100;
    sd = 32'h0011_0000;
    #1;
    chk("t1_idle_v", 32'(mv0), 32'h0);
    chk("t1_idle_r", 32'(sr0), 32'h0);
    @(negedge clk); #1;
    chk("t1_hdr_g", 32'(g0), 32'h4);
    chk("t1_hdr_v", 32'(mv0), 32'h1);
    chk("t1_hdr_d", 32'(md0), 32'hF2);
    chk("t1_hdr_l", 32'(ml0), 32'h0);
    chk("t1_hdr_r", 32'(sr0), 32'h0);
    @(negedge clk); #1;
    chk("t1_d0", 32'(md0), 32'h11);
    chk("t1_d0_r", 32'(sr0), 32'h4);
    chk("t1_d0_l", 32'(ml0), 32'h0);
    @(negedge clk);
    sd = 32'h0022_0000;
    #1;
    chk("t1_d1", 32'(md0), 32'h22);
    chk("t1_d1_l", 32'(ml0), 32'h0);
    @(negedge clk);
    sd = 32'h0033_0000;
    sl = 4'b0100;
    #1;
    chk("t1_d2", 32'(md0), 32'h33);
    chk("t1_d2_l", 32'(ml0), 32'h1);

    // All ports request; ptr is 3 after the previous burst
    @(negedge clk);
    sv = 4'hF;
    sl = 4'hF;
    sd = 32'hA3A2_A1A0;
    #1;
    chk("t2_bubble0", 32'(act0), 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
        chk("t2_bubble", 32'(g0), 32'h0);
      end
      @(negedge clk); #1;
      chk("t2_grant", 32'(g0), 32'(4'b0001 << ((3 + k) % 4)));
      chk("t2_hdr", 32'(md0), 32'hF0 + 32'((3 + k) % 4));
      @(negedge clk); #1;
      chk("t2_data", 32'(md0), 32'hA0 + 32'((3 + k) % 4));
      chk("t2_last", 32'(ml0), 32'h1);
    end

    // Burst cap on the MAX_BURST=4 instance
    do_reset();
    sv = 4'b0011;
    sd = 32'h0000_9950;
    #1;
    chk("t3_idle", 32'(g1), 32'h0);
    @(negedge clk); #1;
    chk("t3_g0", 32'(g1), 32'h1);
    chk("t3_hdr", 32'(md1), 32'hF0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sd[7:0] = 8'h50 + 8'(k);
      #1;
      chk("t3_data", 32'(md1), 32'h50 + 32'(k));
      chk("t3_last", 32'(ml1), 32'(k == 3));
    end
    @(negedge clk); #1;
    chk("t3_bubble", 32'(g1), 32'h0);
    @(negedge clk); #1;
    chk("t3_g1", 32'(g1), 32'h2);
    chk("t3_hdr1", 32'(md1), 32'hF1);

    // Backpressure, ready pattern 1,0,0 repeating
    do_reset();
    words[0] = 8'h61;
    words[1] = 8'h62;
    words[2] = 8'h63;
    wi = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      mr = (c % 3 == 0);
      w  = (wi < 3) ? words[wi] : 8'h00;
      sv = (wi < 3) ? 4'b0010 : 4'b0000;
      sl = (wi == 2) ? 4'b0010 : 4'b0000;
      sd = {16'h0, w, 8'h0};
      #1;
      if (prev_stall) begin
        chk("t4_hold_v", 32'(mv0), 32'h1);
        chk("t4_hold_d", 32'(md0), 32'(prev_d));
      end
      prev_stall = mv0 && !mr;
      prev_d = md0;
      if (mv0 && mr) begin
        got.push_back(md0);
        if (sr0[1]) wi++;
      end
    end
    chk("t4_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("t4_w0", 32'(got[0]), 32'hF1);
      chk("t4_w1", 32'(got[1]), 32'h61);
      chk("t4_w2", 32'(got[2]), 32'h62);
      chk("t4_w3", 32'(got[3]), 32'h63);
    end

    // Reset mid-burst; ptr is 2 before the reset
    do_reset();
    sv = 4'b0010;
    sl = 4'b0010;
    sd = 32'h0000_1100;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_p1_d", 32'(md0), 32'h11);
    chk("t5_p1_l", 32'(ml0), 32'h1);
    @(negedge clk);
    sv = 4'b0100;
    sl = 4'b0000;
    sd = 32'h00AA_0000;
    #1;
    chk("t5_bubble", 32'(act0), 32'h0);
    @(negedge clk); #1;
    chk("t5_g2", 32'(g0), 32'h4);
    @(negedge clk); #1;
    chk("t5_d0", 32'(md0), 32'hAA);
    @(negedge clk);
    sd = 32'h00BB_0000;
    #1;
    chk("t5_d1", 32'(md0), 32'hBB);
    @(negedge clk);
    sd = 32'h00CC_0000;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_g", 32'(g0), 32'h0);
    chk("t5_rst_v", 32'(mv0), 32'h0);
    chk("t5_rst_act", 32'(act0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sv = 4'b0101;
    sd = 32'h00CC_00DD;
    #1;
    chk("t5_idle", 32'(g0), 32'h0);
    @(negedge clk); #1;
    chk("t5_g0", 32'(g0), 32'h1);
    chk("t5_hdr", 32'(md0), 32'hF0);

    // No header, MAX_BURST=1 instance
    do_reset();
    sv = 4'b1000;
    sd = 32'h7700_0000;
    #1;
    chk("t6_idle_v", 32'(mv2), 32'h0);
    @(negedge clk); #1;
    chk("t6_g", 32'(g2), 32'h8);
    chk("t6_v", 32'(mv2), 32'h1);
    chk("t6_d", 32'(md2), 32'h77);
    chk("t6_l", 32'(ml2), 32'h1);
    chk("t6_r", 32'(sr2), 32'h8);
    @(negedge clk);
    sv = 4'b0000;
    #1;
    chk("t6_done", 32'(act2), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
